kf_ppi_gen: RTL and testbench
=============================

Name: kf_ppi_gen

Overview:
Parametrised successor to the team's 8255-style PPI: NUM_PORTS independent ports of PORT_WIDTH bits, each with its own direction, mode and interrupt-enable control.
- Each port runs either in basic mode or in strobed handshake mode, 8255 mode-1 style: STB/IBF for input, OBF/ACK for output.
- Each port has per-port interrupt and overrun status.
- Sits on the XT peripheral bus beside the existing PPI; feeds the interrupt controller through irq.

Parameters:
- NUM_PORTS, 3, number of ports.
- PORT_WIDTH, 8, port and data-bus width; must be >= 8.
- ADDR_WIDTH, 3, address width; must satisfy 2^ADDR_WIDTH >= 2*NUM_PORTS.
- FIFO_DEPTH, 4, input FIFO entries per port; power of 2; used only with KF_PPI_INPUT_FIFO_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- chip_select_n  in  1  bus select.
- read_enable_n  in  1  bus read strobe.
- write_enable_n  in  1  bus write strobe.
- address  in  ADDR_WIDTH  register select.
- data_bus_in  in  PORT_WIDTH  write data.
- data_bus_out  out  PORT_WIDTH  read data.
- port_in  in  NUM_PORTS*PORT_WIDTH  pin inputs; port k occupies bits [k*PORT_WIDTH +: PORT_WIDTH].
- port_out  out  NUM_PORTS*PORT_WIDTH  output latches.
- port_oe  out  NUM_PORTS  1 = port k drives its pins.
- stb_n  in  NUM_PORTS  input strobe.
- ack_n  in  NUM_PORTS  output acknowledge.
- ibf  out  NUM_PORTS  input buffer full.
- obf_n  out  NUM_PORTS  output buffer full, active low.
- port_intr  out  NUM_PORTS  per-port interrupt.
- irq  out  1  OR of port_intr.

Behaviour:
- Register map:
  - Address 2k: data register of port k.
  - Address 2k+1: control (write) / status (read) register of port k.
  - Addresses >= 2*NUM_PORTS: writes ignored, reads return 0.
- Control register bits:
  - [0] dir: 1 = input.
  - [1] mode: 1 = strobed.
  - [2] ie: interrupt enable.
  - Upper bits ignored.
- Status register: {zeros, ovr, intr, flag, ie, mode, dir}, packed from LSB, where flag = ibf when dir=1, else ~obf_n.
- Write commit: data_bus_in and address are registered every cycle. A write commits in the cycle after write_enable_n rises (0→1), provided chip_select_n was 0 in the previous cycle. The committed data and address are those registered in the last cycle write_enable_n was low.
- Read: data_bus_out is combinational and valid while chip_select_n=0 and read_enable_n=0; otherwise it is 0.
- Read side effects happen on the read_enable_n rising edge, with chip_select_n low in the previous cycle.
- All ibf/obf_n/intr flags are registered; they update the cycle after their causing edge.
- stb_n and ack_n edges are detected on their registered previous value; no extra synchroniser is inside the block.
- Reset values:
  - All ports: dir=1, mode=0, ie=0.
  - port_out=0, port_oe=0, ibf=0, obf_n=1, port_intr=0, irq=0.
  - ovr=0, input latches=0.
- Control write:
  - Loads dir, mode and ie.
  - Clears ibf, sets obf_n=1, clears intr and ovr.
  - Does not change port_out.
  - port_oe[k] = ~dir.
- Basic mode (mode=0):
  - Input: data read returns live port_in.
  - Output: data write loads port_out; data read returns port_out.
  - ibf/obf_n/intr are held inactive.
- Strobed input (dir=1, mode=1):
  - stb_n falling edge: latch port_in; set ibf.
    - If ibf was already 1, overwrite the latch and set ovr.
  - stb_n rising edge with ibf=1 and ie=1: set intr.
  - Data read returns the latch; the end of that read clears ibf, intr and ovr.
  - Same-cycle stb_n fall and end of read: the new data is latched and ibf stays 1; intr clears; ovr stays 0.
- Strobed output (dir=0, mode=1):
  - Data write loads port_out, sets obf_n=0 and clears intr.
  - ack_n falling edge clears obf_n to 1.
  - ack_n rising edge with obf_n=1 and ie=1: set intr.
  - Same-cycle data write and ack_n fall: the write wins and obf_n stays 0.
- A control write to one port never affects any other port.
- Reset asserted mid-transfer returns every port to its reset state in the next cycle; no pending flag survives.

Optional Feature:
- Macro: KF_PPI_INPUT_FIFO_EN.
- Defined:
  - Each port gets a FIFO_DEPTH-entry input FIFO; each stb_n fall pushes one entry.
  - ibf = FIFO not empty.
  - Data read returns the head; the end of the read pops one entry.
  - A push while full drops the data and sets ovr.
  - Same-cycle push and pop on a full FIFO is accepted, with no ovr.
  - intr sets on stb_n rise while the FIFO is not empty and ie=1; intr clears when the FIFO becomes empty.
  - Control write empties the FIFO.
- Undefined: single latch as described under Behaviour.

Test Plan:
- Reset, then read status of each port → 0x01 (dir=1); ibf=0, obf_n=1, port_oe=0, irq=0.
- Control write 0x00 to port 1, then data write 0xA5 → port_out[15:8]=0xA5, port_oe[1]=1; data read of port 1 returns 0xA5.
- Port 0 control 0x07; port_in[7:0]=0x3C; pulse stb_n → ibf[0]=1 and irq=1 after stb_n rises; data read returns 0x3C; after the read, ibf=0 and irq=0.
- Port 2 control 0x06; data write 0x5A → obf_n[2]=0; pulse ack_n → obf_n=1, then port_intr[2]=1; next data write clears port_intr[2].
- Port 0 strobed input; two stb_n pulses with 0x11 then 0x22 and no read → without the macro, read gives 0x22 and status ovr=1; with the macro, reads give 0x11 then 0x22, ovr=0.
- Reset asserted while ibf=1 and obf_n=0 → next cycle all flags are at reset values and port_out=0.

Source files
------------

// File: rtl/kf_ppi_gen.sv
// kf_ppi_gen: NUM_PORTS-port PPI, each port in basic or 8255 mode-1 style strobed handshake mode.
// Define KF_PPI_INPUT_FIFO_EN to replace each port's single input latch with a FIFO_DEPTH-entry FIFO.
module kf_ppi_gen #(
    parameter int NUM_PORTS  = 3,
    parameter int PORT_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            chip_select_n,
    input  logic                            read_enable_n,
    input  logic                            write_enable_n,
    input  logic [ADDR_WIDTH-1:0]           address,
    input  logic [PORT_WIDTH-1:0]           data_bus_in,
    output logic [PORT_WIDTH-1:0]           data_bus_out,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] port_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] port_out,
    output logic [NUM_PORTS-1:0]            port_oe,
    input  logic [NUM_PORTS-1:0]            stb_n,
    input  logic [NUM_PORTS-1:0]            ack_n,
    output logic [NUM_PORTS-1:0]            ibf,
    output logic [NUM_PORTS-1:0]            obf_n,
    output logic [NUM_PORTS-1:0]            port_intr,
    output logic                            irq
);
    logic                  r_cs_n, r_we_n, r_re_n;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [PORT_WIDTH-1:0] r_data;
    logic                  w_wr, w_rd;
    logic [PORT_WIDTH-1:0] w_rdata [NUM_PORTS];
    logic [PORT_WIDTH-1:0] w_stat  [NUM_PORTS];

    if (PORT_WIDTH < 8 || (2 ** ADDR_WIDTH) < 2 * NUM_PORTS || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("kf_ppi_gen: illegal parameter combination");
    end

    // Bus is sampled every cycle; a transfer takes effect on the strobe's rising edge.
    always_ff @(posedge clock)
        if (reset) begin
            r_cs_n <= 1'b1;
            r_we_n <= 1'b1;
            r_re_n <= 1'b1;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_cs_n <= chip_select_n;
            r_we_n <= write_enable_n;
            r_re_n <= read_enable_n;
            r_addr <= address;
            r_data <= data_bus_in;
        end

    assign w_wr = ~r_we_n & write_enable_n & ~r_cs_n;
    assign w_rd = ~r_re_n & read_enable_n & ~r_cs_n;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        logic                  r_dir, r_mode, r_ie, r_obf_n, r_intr, r_ovr, r_stb, r_ack;
        logic [PORT_WIDTH-1:0] r_out, w_pin, w_head;
        logic                  w_wr_d, w_wr_c, w_rd_d, w_sin, w_sout, w_ibf;
        logic                  w_fall, w_rise, w_ack_fall, w_ack_rise;
        logic                  w_ovr_set, w_in_set, w_in_clr;
        assign w_pin      = port_in[k*PORT_WIDTH +: PORT_WIDTH];
        assign w_wr_d     = w_wr && r_addr == ADDR_WIDTH'(2 * k);
        assign w_wr_c     = w_wr && r_addr == ADDR_WIDTH'(2 * k + 1);
        assign w_rd_d     = w_rd && r_addr == ADDR_WIDTH'(2 * k);
        assign w_sin      = r_mode & r_dir;
        assign w_sout     = r_mode & ~r_dir;
        assign w_fall     = r_stb & ~stb_n[k];
        assign w_rise     = ~r_stb & stb_n[k];
        assign w_ack_fall = r_ack & ~ack_n[k];
        assign w_ack_rise = ~r_ack & ack_n[k];
`ifdef KF_PPI_INPUT_FIFO_EN
        localparam int QW = $clog2(FIFO_DEPTH);
        logic [PORT_WIDTH-1:0] r_fifo [FIFO_DEPTH];
        logic [QW-1:0]         r_wp, r_rp;
        logic [QW:0]           r_cnt, w_cnt_nxt;
        logic                  w_push, w_pop, w_acc;
        assign w_push    = w_sin & w_fall;
        assign w_pop     = w_sin & w_rd_d & w_ibf;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        assign w_acc     = w_push & ((r_cnt != (QW+1)'(FIFO_DEPTH)) | w_pop);
        assign w_cnt_nxt = r_cnt + (QW+1)'(w_acc) - (QW+1)'(w_pop);
        assign w_ibf     = r_cnt != '0;
        assign w_head    = r_fifo[r_rp];
        assign w_ovr_set = w_push & ~w_acc;
        assign w_in_set  = w_rise & w_ibf & r_ie;
        assign w_in_clr  = w_cnt_nxt == '0;
        always_ff @(posedge clock)
            if (reset || w_wr_c) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_acc) r_wp <= r_wp + 1'b1;
                if (w_pop) r_rp <= r_rp + 1'b1;
                r_cnt <= w_cnt_nxt;
            end
        always_ff @(posedge clock)
            if (reset) r_fifo <= '{default: '0};
            else if (w_acc) r_fifo[r_wp] <= w_pin;
`else
        logic                  r_ibf;
        logic [PORT_WIDTH-1:0] r_latch;
        assign w_ibf     = r_ibf;
        assign w_head    = r_latch;
        assign w_ovr_set = w_fall & r_ibf;
        assign w_in_set  = w_rise & r_ibf & r_ie;
        assign w_in_clr  = w_rd_d;
        // A strobe landing with the end of a read keeps ibf set for the fresh data.
        always_ff @(posedge clock)
            if (reset) begin
                r_ibf   <= 1'b0;
                r_latch <= '0;
            end else if (w_wr_c) begin
                r_ibf <= 1'b0;
            end else if (w_sin) begin
                if (w_fall) begin
                    r_latch <= w_pin;
                    r_ibf   <= 1'b1;
                end else if (w_rd_d) begin
                    r_ibf <= 1'b0;
                end
            end
`endif
        always_ff @(posedge clock)
            if (reset) begin
                r_dir   <= 1'b1;
                r_mode  <= 1'b0;
                r_ie    <= 1'b0;
                r_obf_n <= 1'b1;
                r_intr  <= 1'b0;
                r_ovr   <= 1'b0;
                r_out   <= '0;
                r_stb   <= 1'b1;
                r_ack   <= 1'b1;
            end else begin
                r_stb <= stb_n[k];
                r_ack <= ack_n[k];
                if (w_wr_c) begin
                    r_dir   <= r_data[0];
                    r_mode  <= r_data[1];
                    r_ie    <= r_data[2];
                    r_obf_n <= 1'b1;
                    r_intr  <= 1'b0;
                    r_ovr   <= 1'b0;
                end else if (w_sin) begin
                    r_ovr  <= w_rd_d ? 1'b0 : r_ovr | w_ovr_set;
                    r_intr <= w_in_clr ? 1'b0 : r_intr | w_in_set;
                end else if (~r_dir && w_wr_d) begin
                    r_out   <= r_data;
                    r_obf_n <= ~r_mode;
                    r_intr  <= 1'b0;
                end else if (w_sout) begin
                    if (w_ack_fall) r_obf_n <= 1'b1;
                    if (w_ack_rise && r_obf_n && r_ie) r_intr <= 1'b1;
                end
            end
        assign w_rdata[k] = r_dir ? (r_mode ? w_head : w_pin) : r_out;
        assign w_stat[k]  = {{(PORT_WIDTH-6){1'b0}}, r_ovr, r_intr, r_dir ? w_ibf : ~r_obf_n,
                             r_ie, r_mode, r_dir};
        assign port_out[k*PORT_WIDTH +: PORT_WIDTH] = r_out;
        assign port_oe[k]   = ~r_dir;
        assign ibf[k]       = w_ibf;
        assign obf_n[k]     = r_obf_n;
        assign port_intr[k] = r_intr;
    end

    always_comb begin
        data_bus_out = '0;
        if (!chip_select_n && !read_enable_n)
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (address == ADDR_WIDTH'(2 * i)) data_bus_out = w_rdata[i];
                if (address == ADDR_WIDTH'(2 * i + 1)) data_bus_out = w_stat[i];
            end
    end

    assign irq = |port_intr;
endmodule

// File: tb/tb_kf_ppi_gen.sv
// tb_kf_ppi_gen: directed scoreboard bench for kf_ppi_gen (latch or FIFO input build).
module tb_kf_ppi_gen;
    localparam int NP = 3, PW = 8, AW = 3;
    logic              clock = 1'b0, reset = 1'b1;
    logic              chip_select_n = 1'b1, read_enable_n = 1'b1, write_enable_n = 1'b1;
    logic [AW-1:0]     address = '0;
    logic [PW-1:0]     data_bus_in = '0, data_bus_out;
    logic [NP*PW-1:0]  port_in = '0, port_out;
    logic [NP-1:0]     port_oe, ibf, obf_n, port_intr;
    logic [NP-1:0]     stb_n = '1, ack_n = '1;
    logic              irq;
    int                checks = 0, errors = 0;
    logic [PW-1:0]     rv;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    kf_ppi_gen #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .chip_select_n(chip_select_n),
        .read_enable_n(read_enable_n), .write_enable_n(write_enable_n), .address(address),
        .data_bus_in(data_bus_in), .data_bus_out(data_bus_out), .port_in(port_in),
        .port_out(port_out), .port_oe(port_oe), .stb_n(stb_n), .ack_n(ack_n), .ibf(ibf),
        .obf_n(obf_n), .port_intr(port_intr), .irq(irq)
    );

    always #5 clock = ~clock;

    function automatic void exp_push(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endfunction

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [PW-1:0] d);
        @(negedge clock);
        chip_select_n = 1'b0; write_enable_n = 1'b0; address = a; data_bus_in = d;
        @(negedge clock);
        chip_select_n = 1'b1; write_enable_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic bus_rd(input logic [AW-1:0] a, output logic [PW-1:0] d);
        @(negedge clock);
        chip_select_n = 1'b0; read_enable_n = 1'b0; address = a;
        #1 d = data_bus_out;
        @(negedge clock);
        chip_select_n = 1'b1; read_enable_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic stb_pulse(input int k, input logic [PW-1:0] v);
        @(negedge clock);
        port_in[k*PW +: PW] = v; stb_n[k] = 1'b0;
        @(negedge clock);
        stb_n[k] = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_push("rst_ibf", 0); exp_push("rst_obf_n", 3'b111); exp_push("rst_oe", 0);
        exp_push("rst_irq", 0); exp_push("rst_port_out", 0);
        chk(ibf); chk(obf_n); chk(port_oe); chk(irq); chk(port_out);
        for (int k = 0; k < NP; k++) begin
            exp_push($sformatf("rst_status%0d", k), 8'h01);
            bus_rd(AW'(2 * k + 1), rv); chk(rv);
        end
        exp_push("bad_addr_read", 0);
        bus_rd(3'd6, rv); chk(rv);

        // Port 1 basic output
        exp_push("p1_out", 8'hA5); exp_push("p1_oe", 3'b010); exp_push("p1_read", 8'hA5);
        exp_push("p0_status_untouched", 8'h01);
        bus_wr(3'd3, 8'h00); bus_wr(3'd2, 8'hA5);
        chk(port_out[15:8]); chk(port_oe);
        bus_rd(3'd2, rv); chk(rv);
        bus_rd(3'd1, rv); chk(rv);

        // Port 0 strobed input with interrupt
        exp_push("p0_ibf_set", 1); exp_push("p0_irq_before_rise", 0);
        exp_push("p0_irq_after_rise", 1); exp_push("p0_status_full", 8'h1F);
        exp_push("p0_data", 8'h3C); exp_push("p0_ibf_clr", 0); exp_push("p0_irq_clr", 0);
        bus_wr(3'd1, 8'h07);
        @(negedge clock);
        port_in[7:0] = 8'h3C; stb_n[0] = 1'b0;
        @(negedge clock);
        chk(ibf[0]); chk(irq);
        stb_n[0] = 1'b1;
        @(negedge clock);
        chk(irq);
        port_in[7:0] = 8'hFF;
        bus_rd(3'd1, rv); chk(rv);
        bus_rd(3'd0, rv); chk(rv);
        chk(ibf[0]); chk(irq);

        // Port 2 strobed output with interrupt
        exp_push("p2_obf_low", 0); exp_push("p2_out", 8'h5A); exp_push("p2_obf_after_ack", 1);
        exp_push("p2_intr_before_rise", 0); exp_push("p2_intr_after_rise", 1);
        exp_push("p2_status", 8'h16); exp_push("p2_intr_clr_by_write", 0);
        exp_push("p2_obf_low2", 0);
        bus_wr(3'd5, 8'h06); bus_wr(3'd4, 8'h5A);
        chk(obf_n[2]); chk(port_out[23:16]);
        ack_n[2] = 1'b0;
        @(negedge clock);
        chk(obf_n[2]); chk(port_intr[2]);
        ack_n[2] = 1'b1;
        @(negedge clock);
        chk(port_intr[2]);
        bus_rd(3'd5, rv); chk(rv);
        bus_wr(3'd4, 8'h77);
        chk(port_intr[2]); chk(obf_n[2]);

        // Data write and ack_n fall on the same cycle: the write wins
        exp_push("p2_write_wins_obf", 0); exp_push("p2_write_wins_out", 8'h99);
        exp_push("p2_no_intr_obf_low", 0);
        @(negedge clock);
        chip_select_n = 1'b0; write_enable_n = 1'b0; address = 3'd4; data_bus_in = 8'h99;
        @(negedge clock);
        chip_select_n = 1'b1; write_enable_n = 1'b1; ack_n[2] = 1'b0;
        @(negedge clock);
        chk(obf_n[2]); chk(port_out[23:16]);
        ack_n[2] = 1'b1;
        @(negedge clock);
        chk(port_intr[2]);

        // Two strobes without a read
`ifdef KF_PPI_INPUT_FIFO_EN
        exp_push("p0_status_2strobes", 8'h1F); exp_push("p0_first", 8'h11);
        exp_push("p0_second", 8'h22); exp_push("p0_ibf_drained", 0);
        stb_pulse(0, 8'h11); stb_pulse(0, 8'h22);
        bus_rd(3'd1, rv); chk(rv);
        bus_rd(3'd0, rv); chk(rv);
        bus_rd(3'd0, rv); chk(rv);
        chk(ibf[0]);
`else
        exp_push("p0_status_2strobes", 8'h3F); exp_push("p0_overwritten", 8'h22);
        exp_push("p0_ibf_drained", 0); exp_push("p0_status_clr", 8'h07);
        stb_pulse(0, 8'h11); stb_pulse(0, 8'h22);
        bus_rd(3'd1, rv); chk(rv);
        bus_rd(3'd0, rv); chk(rv);
        chk(ibf[0]);
        bus_rd(3'd1, rv); chk(rv);
`endif

        // Reset mid-transfer
        exp_push("pre_rst_ibf0", 1); exp_push("pre_rst_obf2", 0);
        exp_push("mid_rst_ibf", 0); exp_push("mid_rst_obf_n", 3'b111);
        exp_push("mid_rst_port_out", 0); exp_push("mid_rst_intr", 0);
        exp_push("mid_rst_irq", 0); exp_push("mid_rst_oe", 0);
        exp_push("post_rst_status0", 8'h01);
        stb_pulse(0, 8'h44);
        chk(ibf[0]); chk(obf_n[2]);
        reset = 1'b1;
        @(negedge clock);
        chk(ibf); chk(obf_n); chk(port_out); chk(port_intr); chk(irq); chk(port_oe);
        reset = 1'b0;
        bus_rd(3'd1, rv); chk(rv);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
